// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
// Generic inter-stage pipeline register with a valid/ready handshake and a
// two-entry skid buffer (main + skid). The control field reads as zero
// whenever the head is empty, so a bubble is always a NOP. The data field
// keeps its last value. In_Ready comes straight from a register and has no
// combinational path from Out_Ready.
// Optional statistics counters (Stall_Cnt, Flush_Cnt) are built only when
// the macro PIPE_STAT_EN is defined.
module pipe_stage_skid_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
`ifdef PIPE_STAT_EN
  ,
  output logic [15:0]       Stall_Cnt,
  output logic [15:0]       Flush_Cnt
`endif
);

  logic              main_valid;
  logic              skid_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] skid_data;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = In_Valid && in_ready_q;
  assign out_fire = main_valid && Out_Ready;

  // Entry storage: main feeds the outputs, skid absorbs one entry of back-pressure.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      // NOTE: the payload registers are reset too because Out_Data must read
      // zero after reset; skid payload follows so both entries look alike.
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (Flush) begin
      // Any input firing now is dropped; any output firing now was consumed.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case ({skid_valid, main_valid})
        2'b00: begin
          if (in_fire) begin
            main_valid <= 1'b1;
            main_ctrl  <= In_Ctrl;
            main_data  <= In_Data;
          end
        end
        2'b01: begin
          if (in_fire && out_fire) begin
            main_ctrl <= In_Ctrl;
            main_data <= In_Data;
          end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_ctrl  <= In_Ctrl;
            skid_data  <= In_Data;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            main_valid <= 1'b0;
          end
        end
        default: begin
          // Full: In_Ready is low, so the only event is the head leaving.
          if (out_fire) begin
            main_ctrl  <= skid_ctrl;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = main_valid;
  assign Out_Ctrl  = main_valid ? main_ctrl : '0;
  assign Out_Data  = main_data;
  assign Occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

`ifdef PIPE_STAT_EN
  // Saturating stall and flush counters; only reset clears them.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      Stall_Cnt <= '0;
      Flush_Cnt <= '0;
    end else begin
      if (main_valid && !Out_Ready && (Stall_Cnt != 16'hFFFF))
        Stall_Cnt <= Stall_Cnt + 16'd1;
      if (Flush && (main_valid || skid_valid) && (Flush_Cnt != 16'hFFFF))
        Flush_Cnt <= Flush_Cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_skid_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_STAT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_reg #(.CTRL_W(8), .DATA_W(32)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .Flush     (flush),
    .In_Valid  (in_valid),
    .In_Ready  (in_ready),
    .In_Ctrl   (in_ctrl),
    .In_Data   (in_data),
    .Out_Valid (out_valid),
    .Out_Ready (out_ready),
    .Out_Ctrl  (out_ctrl),
    .Out_Data  (out_data),
    .Occupancy (occupancy)
`ifdef PIPE_STAT_EN
    ,
    .Stall_Cnt (stall_cnt),
    .Flush_Cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of at most two entries.
  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } entry_t;

  entry_t      m_q[$];
  bit          m_ready = 1'b1;
  logic [31:0] m_last  = '0;
  bit          m_live  = 1'b0;
  int          m_stall = 0;
  int          m_flush = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_q.delete();
        m_ready = 1'b1;
        m_last  = '0;
        m_live  = 1'b1;
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (m_q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
        if (flush && m_q.size() > 0 && m_flush < 65535) m_flush++;
        if (flush) begin
          m_q.delete();
          m_ready = 1'b1;
        end else begin
          bit in_f;
          in_f = in_valid && m_ready;
          if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
          if (in_f) m_q.push_back('{c: in_ctrl, d: in_data});
          m_ready = (m_q.size() < 2);
        end
        if (m_q.size() > 0) m_last = m_q[0].d;
      end
    end
  end

  // Compare every cycle on the falling edge, once the model has seen reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("model_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
        check("model_ctrl", {24'd0, out_ctrl}, (m_q.size() > 0) ? {24'd0, m_q[0].c} : 32'd0);
        check("model_data", out_data, (m_q.size() > 0) ? m_q[0].d : m_last);
        check("model_occ", {30'd0, occupancy}, m_q.size());
        check("model_ready", {31'd0, in_ready}, {31'd0, m_ready});
`ifdef PIPE_STAT_EN
        check("model_stall_cnt", {16'd0, stall_cnt}, m_stall);
        check("model_flush_cnt", {16'd0, flush_cnt}, m_flush);
`endif
      end
    end
  end

  // Advance one clock; new inputs are driven 2 time units after the edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ctrl = 8'h00; in_data = 32'h0;
    step(); step();
    check("reset_valid", {31'd0, out_valid}, 32'd0);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    check("reset_occ", {30'd0, occupancy}, 32'd0);
    check("reset_data", out_data, 32'd0);
    rst = 1'b1;
    step();

    // Streaming at full rate.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_ctrl = 8'h5A; in_data = i;
      step();
      check("stream_data", out_data, i);
      check("stream_ctrl", {24'd0, out_ctrl}, 32'h5A);
      check("stream_occ", {30'd0, occupancy}, 32'd1);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_occ", {30'd0, occupancy}, 32'd0);

    // Back-pressure: A in main, B in skid, C held upstream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h01; in_data = 32'hA; step();
    in_data = 32'hB; step();
    check("bp_occ_full", {30'd0, occupancy}, 32'd2);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    in_data = 32'hC; step();
    check("bp_head_a", out_data, 32'hA);
    check("bp_occ_hold", {30'd0, occupancy}, 32'd2);
    out_ready = 1'b1; step();
    check("bp_head_b", out_data, 32'hB);
    check("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_head_c", out_data, 32'hC);
    in_valid = 1'b0; step();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush at full with an input offered.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h33; in_data = 32'h11; step();
    in_data = 32'h22; step();
    check("fl_occ_full", {30'd0, occupancy}, 32'd2);
    flush = 1'b1; in_data = 32'hD; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_ctrl", {24'd0, out_ctrl}, 32'd0);
    check("fl_occ", {30'd0, occupancy}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; step(); step();
    check("fl_d_gone", {31'd0, out_valid}, 32'd0);

    // Flush at occupancy 1 while an input would fire.
    in_valid = 1'b1; in_ctrl = 8'h44; in_data = 32'h55; step();
    flush = 1'b1; in_data = 32'h66; step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_occ", {30'd0, occupancy}, 32'd0);
    step();
    check("fl1_in_dropped", {31'd0, out_valid}, 32'd0);

    // Reset mid-stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h12; in_data = 32'h1; step();
    in_data = 32'h2; step();
    check("rs_occ_full", {30'd0, occupancy}, 32'd2);
    rst = 1'b0; in_valid = 1'b0; step();
    rst = 1'b1;
    check("rs_valid", {31'd0, out_valid}, 32'd0);
    check("rs_occ", {30'd0, occupancy}, 32'd0);
    check("rs_data", out_data, 32'd0);
    check("rs_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 8'h07; in_data = 32'h77; step();
    in_valid = 1'b0;
    check("rs_first_data", out_data, 32'h77);
    check("rs_first_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Bubbles with a non-zero control pattern on the input.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; in_ctrl = 8'hFF; in_data = 32'hDEAD_BEEF;
      step();
      check("bubble_valid", {31'd0, out_valid}, 32'd0);
      check("bubble_ctrl", {24'd0, out_ctrl}, 32'd0);
    end

`ifdef PIPE_STAT_EN
    rst = 1'b0; step(); rst = 1'b1;
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h01; in_data = 32'h9; step();
    in_valid = 1'b0;
    repeat (5) step();
    out_ready = 1'b1; flush = 1'b1; step();
    flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b1; in_data = 32'hA; step();
    in_valid = 1'b0; flush = 1'b1; step();
    flush = 1'b0; step();
    check("stat_stall", {16'd0, stall_cnt}, 32'd5);
    check("stat_flush", {16'd0, flush_cnt}, 32'd2);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
